// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg
// Shared definitions for the MIPS memory stage: store opcode encodings
// (instruction[28:26]), the store FSM state type and the byteenable
// patterns used by both the store-side lane formatter and the load formatter.
package mips_mem_pkg;

    // Store type field, instruction[28:26]
    localparam logic [2:0] OP_SB = 3'b000;
    localparam logic [2:0] OP_SH = 3'b001;
    localparam logic [2:0] OP_SW = 3'b011;

    // Byteenable patterns (bit n enables byte lane n, bits 8n+7:8n)
    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_H0   = 4'b0011;
    localparam logic [3:0] BE_H2   = 4'b1100;
    localparam logic [3:0] BE_W    = 4'b1111;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

endpackage

// File: rtl/store_lane_formatter.sv
// store_lane_formatter
// Purely combinational lane mapping for SB/SH/SW. The mapping is the exact
// inverse of the load-side endian conversion: the least significant byte of
// the register goes to the highest-addressed lane of the access.
// Ports:
//   i_opcode     store type (instruction[28:26])
//   i_offset     byte offset addr[1:0]
//   i_rt_data    register value to store
//   o_writedata  lane-formatted data, disabled lanes are zero
//   o_byteenable active lanes
//   o_fault      misaligned access or unsupported opcode
module store_lane_formatter
    import mips_mem_pkg::*;
(
    input  logic [2:0]  i_opcode,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_rt_data,
    output logic [31:0] o_writedata,
    output logic [3:0]  o_byteenable,
    output logic        o_fault
);

    always_comb begin
        o_writedata  = 32'h0;
        o_byteenable = BE_NONE;
        o_fault      = 1'b0;
        case (i_opcode)
            OP_SB: begin
                o_byteenable = BE_B0 << i_offset;
                o_writedata  = {24'h0, i_rt_data[7:0]} << {i_offset, 3'b000};
            end
            OP_SH: begin
                case (i_offset)
                    2'd0: begin
                        o_byteenable = BE_H0;
                        o_writedata  = {16'h0, i_rt_data[7:0], i_rt_data[15:8]};
                    end
                    2'd2: begin
                        o_byteenable = BE_H2;
                        o_writedata  = {i_rt_data[7:0], i_rt_data[15:8], 16'h0};
                    end
                    default: o_fault = 1'b1;  // odd halfword offset
                endcase
            end
            OP_SW: begin
                if (i_offset == 2'd0) begin
                    o_byteenable = BE_W;
                    o_writedata  = {i_rt_data[7:0], i_rt_data[15:8],
                                    i_rt_data[23:16], i_rt_data[31:24]};
                end else begin
                    o_fault = 1'b1;
                end
            end
            default: o_fault = 1'b1;  // unsupported store type
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// store_unit
// Memory-stage store engine. Accepts one SB/SH/SW request, formats the byte
// lanes and issues a single Avalon-MM write, held through waitrequest.
// Handshake: a request is taken when start=1 in IDLE; the write is on the bus
// the next cycle and stays constant while avm_waitrequest=1; the edge that
// samples avm_waitrequest=0 completes it and done pulses for one cycle. Faulty
// requests never touch the bus and pulse done+misaligned the next cycle.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start                 request strobe, sampled only in IDLE
//   instruction           store instruction, [28:26] = store type
//   addr, rt_data         effective byte address and value to store
//   stall                 write outstanding (state == WRITE)
//   done, misaligned      completion / fault pulses
//   avm_*                 Avalon-MM write master
//   dbg_state             current FSM state
module store_unit
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       instruction,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       rt_data,
    output logic              stall,
    output logic              done,
    output logic              misaligned,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    output state_t            dbg_state
);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("store_unit: DATA_W must be 32");
    end

    state_t              r_state;
    logic                r_done;
    logic                r_misaligned;
    logic                r_write;
    logic [ADDR_W-1:0]   r_address;
    logic [DATA_W-1:0]   r_writedata;
    logic [3:0]          r_byteenable;

    logic [31:0]         w_writedata;
    logic [3:0]          w_byteenable;
    logic                w_fault;
    logic                w_unused_instr;

    // Only the store-type field of the instruction matters here
    assign w_unused_instr = ^{instruction[31:29], instruction[25:0]};

    store_lane_formatter u_fmt (
        .i_opcode     (instruction[28:26]),
        .i_offset     (addr[1:0]),
        .i_rt_data    (rt_data),
        .o_writedata  (w_writedata),
        .o_byteenable (w_byteenable),
        .o_fault      (w_fault)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
            r_write      <= 1'b0;
            r_address    <= '0;
            r_writedata  <= '0;
            r_byteenable <= 4'b0000;
        end else begin
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_fault) begin
                            r_done       <= 1'b1;
                            r_misaligned <= 1'b1;
                        end else begin
                            r_address    <= {addr[ADDR_W-1:2], 2'b00};
                            r_writedata  <= w_writedata;
                            r_byteenable <= w_byteenable;
                            r_write      <= 1'b1;
                            r_state      <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    // start is ignored here; bus outputs hold until accepted
                    if (!avm_waitrequest) begin
                        r_write <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign stall          = (r_state == WRITE);
    assign done           = r_done;
    assign misaligned     = r_misaligned;
    assign avm_address    = r_address;
    assign avm_write      = r_write;
    assign avm_writedata  = r_writedata;
    assign avm_byteenable = r_byteenable;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_store_unit.sv
module tb_store_unit;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] instruction = 32'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] rt_data = 32'h0;
    logic        stall, done, misaligned, avm_write;
    logic [31:0] avm_address, avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest = 1'b0;
    state_t      dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // expected write: {word address, byteenable, writedata}
    logic [67:0] exp_q[$];

    store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .instruction     (instruction),
        .addr            (addr),
        .rt_data         (rt_data),
        .stall           (stall),
        .done            (done),
        .misaligned      (misaligned),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest),
        .dbg_state       (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [2:0] op);
        return {3'b101, op, 26'h0};
    endfunction

    // compare the bus against the next scoreboard entry
    task automatic check_bus(input string tag);
        logic [67:0] e;
        if (exp_q.size() == 0) begin
            check_eq({tag, ".queue"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq({tag, ".addr"}, avm_address, e[67:36]);
            check_eq({tag, ".be"}, 32'(avm_byteenable), 32'(e[35:32]));
            check_eq({tag, ".wd"}, avm_writedata, e[31:0]);
        end
    endtask

    task automatic drive_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        start       = 1'b1;
        instruction = mk_instr(op);
        addr        = a;
        rt_data     = d;
    endtask

    // legal store with waitrequest low
    task automatic run_store(input string tag, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] be, input logic [31:0] wd);
        exp_q.push_back({a & 32'hFFFF_FFFC, be, wd});
        @(negedge clk);
        drive_start(op, a, d);
        @(negedge clk);
        start = 1'b0;
        check_bus(tag);
        check_eq({tag, ".write"}, 32'(avm_write), 32'd1);
        check_eq({tag, ".stall"}, 32'(stall), 32'd1);
        check_eq({tag, ".done_early"}, 32'(done), 32'd0);
        @(negedge clk);
        check_eq({tag, ".done"}, 32'(done), 32'd1);
        check_eq({tag, ".mis"}, 32'(misaligned), 32'd0);
        check_eq({tag, ".write_off"}, 32'(avm_write), 32'd0);
        check_eq({tag, ".stall_off"}, 32'(stall), 32'd0);
    endtask

    // faulting request: no bus activity, one-cycle done+misaligned
    task automatic run_fault(input string tag, input logic [2:0] op, input logic [31:0] a);
        @(negedge clk);
        drive_start(op, a, 32'hDEAD_BEEF);
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, ".done"}, 32'(done), 32'd1);
        check_eq({tag, ".mis"}, 32'(misaligned), 32'd1);
        check_eq({tag, ".write"}, 32'(avm_write), 32'd0);
        check_eq({tag, ".stall"}, 32'(stall), 32'd0);
        check_eq({tag, ".state"}, 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        check_eq({tag, ".done_off"}, 32'(done), 32'd0);
        check_eq({tag, ".mis_off"}, 32'(misaligned), 32'd0);
        check_eq({tag, ".write_off"}, 32'(avm_write), 32'd0);
    endtask

    initial begin
        logic [31:0] sb_wd[4];
        sb_wd[0] = 32'h0000_00A5;
        sb_wd[1] = 32'h0000_A500;
        sb_wd[2] = 32'h00A5_0000;
        sb_wd[3] = 32'hA500_0000;

        // reset state
        repeat (2) @(negedge clk);
        check_eq("rst.stall", 32'(stall), 32'd0);
        check_eq("rst.done", 32'(done), 32'd0);
        check_eq("rst.mis", 32'(misaligned), 32'd0);
        check_eq("rst.write", 32'(avm_write), 32'd0);
        check_eq("rst.addr", avm_address, 32'h0);
        check_eq("rst.wd", avm_writedata, 32'h0);
        check_eq("rst.be", 32'(avm_byteenable), 32'h0);
        check_eq("rst.state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b0;

        // directed legal stores
        run_store("sw0", OP_SW, 32'h0000_1000, 32'h1122_3344, 4'b1111, 32'h4433_2211);
        run_store("sh2", OP_SH, 32'h0000_1002, 32'h0000_ABCD, 4'b1100, 32'hCDAB_0000);
        run_store("sh0", OP_SH, 32'h0000_1004, 32'h0000_ABCD, 4'b0011, 32'h0000_CDAB);
        for (int i = 0; i < 4; i++) begin
            run_store($sformatf("sb%0d", i), OP_SB, 32'h0000_2000 + 32'(i), 32'h0000_00A5,
                      4'(1 << i), sb_wd[i]);
        end
        // upper register bytes must not leak into a byte store
        run_store("sb_hi", OP_SB, 32'h0000_2002, 32'hFFFF_FF3C, 4'b0100, 32'h003C_0000);

        // faults
        run_fault("f_sh1", OP_SH, 32'h0000_1001);
        run_fault("f_sh3", OP_SH, 32'h0000_1003);
        run_fault("f_sw2", OP_SW, 32'h0000_1002);
        run_fault("f_sw1", OP_SW, 32'h0000_1001);
        run_fault("f_op2", 3'b010, 32'h0000_1000);
        run_fault("f_op6", 3'b110, 32'h0000_1000);

        // waitrequest held for three sampled edges, ignored start, back-to-back
        avm_waitrequest = 1'b1;
        @(negedge clk);
        drive_start(OP_SW, 32'h0000_3000, 32'hCAFE_F00D);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) begin
                exp_q.push_back({32'h0000_3000, 4'b1111, 32'h0DF0_FECA});
                check_bus("wr_first");
                drive_start(OP_SB, 32'h0000_4001, 32'h0000_0077);  // must be ignored
            end else begin
                start = 1'b0;
            end
            check_eq($sformatf("wr%0d.addr", c), avm_address, 32'h0000_3000);
            check_eq($sformatf("wr%0d.be", c), 32'(avm_byteenable), 32'hF);
            check_eq($sformatf("wr%0d.wd", c), avm_writedata, 32'h0DF0_FECA);
            check_eq($sformatf("wr%0d.write", c), 32'(avm_write), 32'd1);
            check_eq($sformatf("wr%0d.stall", c), 32'(stall), 32'd1);
            check_eq($sformatf("wr%0d.done", c), 32'(done), 32'd0);
        end
        avm_waitrequest = 1'b0;
        @(negedge clk);
        check_eq("wr.done", 32'(done), 32'd1);
        check_eq("wr.write_off", 32'(avm_write), 32'd0);
        check_eq("wr.stall_off", 32'(stall), 32'd0);
        exp_q.push_back({32'h0000_2000, 4'b0010, 32'h0000_5A00});
        drive_start(OP_SB, 32'h0000_2001, 32'h0000_005A);
        @(negedge clk);
        start = 1'b0;
        check_bus("b2b");
        check_eq("b2b.write", 32'(avm_write), 32'd1);
        check_eq("b2b.done_off", 32'(done), 32'd0);
        @(negedge clk);
        check_eq("b2b.done", 32'(done), 32'd1);

        // reset in the middle of a stalled write
        avm_waitrequest = 1'b1;
        @(negedge clk);
        drive_start(OP_SW, 32'h0000_5000, 32'h1234_5678);
        @(negedge clk);
        start = 1'b0;
        check_eq("rw.write", 32'(avm_write), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("rw.write_off", 32'(avm_write), 32'd0);
        check_eq("rw.stall_off", 32'(stall), 32'd0);
        check_eq("rw.done", 32'(done), 32'd0);
        check_eq("rw.addr", avm_address, 32'h0);
        check_eq("rw.state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        reset = 1'b0;
        avm_waitrequest = 1'b0;
        check_eq("rw.done_after", 32'(done), 32'd0);
        run_store("post_rst", OP_SB, 32'h0000_3003, 32'h0000_00C3, 4'b1000, 32'hC300_0000);

        check_eq("sb.empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Write-side counterpart of the load formatter, inside the MIPS CPU memory stage.
- Accepts one store request (SB, SH, SW) from the datapath and computes the byteenable and the byte-lane data.
- Lane mapping is the exact inverse of the load-side endian conversion.
- Drives an Avalon-MM style write on the data bus, holds it through waitrequest, then reports completion or a misalignment fault.

Parameters:
- ADDR_W, 32, width of the CPU address and the bus address.
- DATA_W, 32, data bus width; fixed at 32, and any other value is illegal.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  store request, sampled only in IDLE.
- instruction  in  32  store instruction; instruction[28:26] selects the store type.
- addr  in  ADDR_W  effective byte address (base + offset).
- rt_data  in  32  register value to store.
- stall  out  1  high while a write is outstanding; the CPU freezes the pipeline.
- done  out  1  one-cycle pulse when the request has finished or faulted.
- misaligned  out  1  one-cycle pulse, coincident with done, for an alignment fault.
- avm_address  out  ADDR_W  word-aligned bus address {addr[ADDR_W-1:2], 2'b00}.
- avm_write  out  1  bus write strobe.
- avm_writedata  out  32  lane-formatted data.
- avm_byteenable  out  4  active lanes.
- avm_waitrequest  in  1  slave not ready; hold all avm_* outputs stable.

Behaviour:
- Reset values (asynchronous, apply immediately):
  - state = IDLE.
  - stall, done, misaligned, avm_write = 0.
  - avm_address, avm_writedata, avm_byteenable = 0.
- All outputs are registered; stall is decoded from the state register.
- Opcode decode on instruction[28:26]:
  - 000 = SB, 001 = SH, 011 = SW.
  - Any other value on start is an unsupported request and is treated as a fault (misaligned=1).
- Lane mapping for byte offset o = addr[1:0]:
  - SB: byteenable bit o set. Lane o (bits 8o+7:8o) = rt_data[7:0].
  - SH, o=0: byteenable 0011. Lane0 = rt_data[15:8], lane1 = rt_data[7:0].
  - SH, o=2: byteenable 1100. Lane2 = rt_data[15:8], lane3 = rt_data[7:0].
  - SW, o=0: byteenable 1111. writedata = {rt_data[7:0], rt_data[15:8], rt_data[23:16], rt_data[31:24]}.
  - Disabled lanes drive 0.
- Alignment faults: SH with o odd, SW with o != 0.
- FSM state IDLE:
  - start=1 with a legal request: latch address, data and byteenable. Set avm_write=1 and go to WRITE; the write appears on the bus the cycle after start.
  - start=1 with a fault or unsupported opcode: no bus activity. Pulse done and misaligned next cycle; stay in IDLE.
  - start=0: nothing happens.
- FSM state WRITE:
  - stall=1.
  - avm_* held constant while avm_waitrequest=1.
  - At the edge where avm_waitrequest=0 is sampled: avm_write←0, done←1 for one cycle, return to IDLE.
  - Minimum latency: start sampled at edge N, write visible cycle N+1, done visible cycle N+2.
- start while in WRITE is ignored. The CPU must not assert it, because stall is high.
- A new start is accepted in the same cycle that done is high (back-to-back stores, one idle-free turnaround).
- avm_waitrequest is ignored outside WRITE.
- Reset asserted mid-WRITE: avm_write drops asynchronously and no done pulse is produced. The store is lost, and the bus slave must tolerate the aborted write.
- No reads are ever issued by this block.

Decomposition:
- mips_mem_pkg holds:
  - the store opcode constants (OP_SB=3'b000, OP_SH=3'b001, OP_SW=3'b011);
  - the state enum (IDLE, WRITE);
  - the byteenable constants shared with the load formatter.
- One combinational sub-module, store_lane_formatter (opcode, addr[1:0], rt_data → writedata, byteenable, fault). The same lane tables can be reused to cross-check the load formatter.
- store_unit itself holds only the FSM and the output registers.

Test Plan:
- SW, addr 0x00001000, rt 0x11223344, waitrequest=0:
  - Cycle N+1: address 0x00001000, byteenable 1111, writedata 0x44332211, avm_write=1, stall=1.
  - Cycle N+2: done=1, avm_write=0, stall=0.
- SH, addr 0x00001002, rt 0x0000ABCD → byteenable 1100, writedata 0xCDAB0000, address 0x00001000.
- SB to each offset 0..3 of 0x00002000, rt 0x000000A5 → byteenable 0001/0010/0100/1000, writedata 0x000000A5 / 0x0000A500 / 0x00A50000 / 0xA5000000.
- SH at addr 0x00001001, and SW at addr 0x00001002:
  - No avm_write ever.
  - done=1 and misaligned=1 for exactly one cycle at N+1; state stays IDLE.
- SW with waitrequest held high 3 cycles:
  - avm_* stable for 4 cycles; done only after the cycle waitrequest=0 is sampled.
  - Second start pulsed during stall is ignored.
  - Back-to-back start on the done cycle gives the next write one cycle later.
- Reset asserted during WRITE with waitrequest=1: avm_write, stall and done all 0 immediately. After release the unit is in IDLE and accepts a fresh SB normally.
